// File: rtl/vga_pkg.sv
// Shared raster timing constants and coordinate types for the VGA output path
// (timing generator, colour stage and VDP fetch logic).
package vga_pkg;

  // 640x480@60 defaults
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam int unsigned V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef logic [9:0] col_t;
  typedef logic [8:0] row_t;
  typedef logic [9:0] cnt_t;

  // Half-open window test [lo, hi), unsigned.
  function automatic logic in_window(cnt_t val, cnt_t lo, cnt_t hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/vga_timing_pix_tick_gen.sv
// Pixel-rate divider: tick is high for one clk out of every CLK_DIV.
module pix_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned DivW = $clog2(CLK_DIV) + 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  logic [DivW-1:0] div_q, div_d;

  // Next divider value: count up and wrap after CLK_DIV-1.
  always_comb begin
    div_d = div_q + 1'b1;
    if (div_q == DivLast) begin
      div_d = '0;
    end
  end

  // Divider state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // With CLK_DIV=1 DivLast is 0 and div_q never leaves 0, so tick is constant 1.
  assign tick = (div_q == DivLast);

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: pixel-rate divider, h/v counters (stage 0) and a
// registered decode stage (stage 1) producing syncs, blank, coordinates and strobes.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic HSync,
  output logic VSync,
  output logic blank,
  output row_t row,
  output col_t col,
  output logic pix_en,
  output logic line_start,
  output logic frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Every boundary below must be representable in the 10-bit counters.
  if (H_TOTAL > 1023 || V_TOTAL > 1023) begin : g_bad_total
    $error("vga_timing: H_TOTAL/V_TOTAL must fit in 10 bits");
  end
  if (V_ACTIVE > 512) begin : g_bad_row
    $error("vga_timing: V_ACTIVE must fit the 9-bit row output");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing: CLK_DIV must be >= 1");
  end

  localparam cnt_t HLast     = cnt_t'(H_TOTAL - 1);
  localparam cnt_t VLast     = cnt_t'(V_TOTAL - 1);
  localparam cnt_t HActEnd   = cnt_t'(H_ACTIVE);
  localparam cnt_t VActEnd   = cnt_t'(V_ACTIVE);
  localparam cnt_t HSyncLo   = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HSyncHi   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t VSyncLo   = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VSyncHi   = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

  logic tick;

  pix_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_pix_tick_gen (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // Stage 0 counters
  cnt_t h_cnt_q, h_cnt_d;
  cnt_t v_cnt_q, v_cnt_d;

  // Stage 1 decode registers
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic blank_q, blank_d;
  row_t row_q, row_d;
  col_t col_q, col_d;
  logic pix_en_q, pix_en_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  logic active;

  // Counter next-state: h advances per pixel, v advances on h wrap.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (tick) begin
      if (h_cnt_q == HLast) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  assign active = (h_cnt_q < HActEnd) && (v_cnt_q < VActEnd);

  // Decode of the current counters; level outputs hold between ticks, strobes do not.
  always_comb begin
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    blank_d       = blank_q;
    row_d         = row_q;
    col_d         = col_q;
    pix_en_d      = tick;
    line_start_d  = tick && (h_cnt_q == '0);
    frame_start_d = tick && (h_cnt_q == '0) && (v_cnt_q == '0);
    if (tick) begin
      hsync_d = ~in_window(h_cnt_q, HSyncLo, HSyncHi);
      vsync_d = ~in_window(v_cnt_q, VSyncLo, VSyncHi);
      blank_d = ~active;
      col_d   = active ? h_cnt_q : '0;
      row_d   = active ? v_cnt_q[8:0] : '0;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Decode registers; reset drives the idle (sync high, blanked) state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      blank_q       <= 1'b1;
      row_q         <= '0;
      col_q         <= '0;
      pix_en_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_q       <= blank_d;
      row_q         <= row_d;
      col_q         <= col_d;
      pix_en_q      <= pix_en_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign HSync       = hsync_q;
  assign VSync       = vsync_q;
  assign blank       = blank_q;
  assign row         = row_q;
  assign col         = col_q;
  assign pix_en      = pix_en_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
